// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and width helpers for the FIFO write arbiter.
//   arb_state_t : arbiter FSM state encoding (ST_IDLE, ST_GRANT)
//   f_id_w      : width of a producer index for n producers
//   f_cnt_w     : width of a beat counter that must hold 0..b
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   localparam int C_DEF_WIDTH   = 8;
   localparam int C_DEF_NUM_REQ = 4;
   localparam int C_DEF_BURST   = 4;

   // Index width; a single producer still needs one bit to stay legal.
   function automatic int f_id_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Counter width able to represent the full burst length itself.
   function automatic int f_cnt_w(input int b);
      return (b <= 1) ? 1 : $clog2(b + 1);
   endfunction

   localparam int C_ID_W  = f_id_w(C_DEF_NUM_REQ);
   localparam int C_CNT_W = f_cnt_w(C_DEF_BURST);

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector.
//   req    : request vector, one bit per producer
//   last   : index of the previous winner (lowest priority this pick)
//   valid  : at least one request is set
//   winner : first requesting index scanning upward from last+1, wrapping
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter int G_N    = 4,
   parameter int G_ID_W = 2
) (
   input  logic [G_N-1:0]    req,
   input  logic [G_ID_W-1:0] last,
   output logic              valid,
   output logic [G_ID_W-1:0] winner
);

   // Candidate index for each scan offset (offset gi+1 after last).
   logic [G_ID_W-1:0] cand [G_N];

   genvar gi;
   generate
      for (gi = 0; gi < G_N; gi++) begin : g_cand
         assign cand[gi] = G_ID_W'((int'(last) + gi + 1) % G_N);
      end
   endgenerate

   // Scan from the farthest offset down so the nearest hit is assigned last
   // and therefore wins.
   always_comb begin
      valid  = |req;
      winner = '0;
      for (int off = G_N - 1; off >= 0; off--) begin
         if (req[cand[off]]) begin
            winner = cand[off];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among G_NUM_REQ producers.
// A grant lasts for at most G_BURST accepted beats; FIFO full stalls the
// burst without ending it.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_req        : per-producer beat-valid
//   i_data       : packed producer lanes, lane k = [k*G_WIDTH +: G_WIDTH]
//   i_fifo_full  : FIFO full flag
//   o_ack        : one-hot (or zero) beat accept per producer
//   o_wr, o_data : FIFO write strobe and data
//   o_grant_id   : current owner index
//   o_busy       : a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int G_WIDTH   = 8,
   parameter int G_NUM_REQ = 4,
   parameter int G_BURST   = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [G_NUM_REQ-1:0]          i_req,
   input  logic [G_NUM_REQ*G_WIDTH-1:0]  i_data,
   input  logic                          i_fifo_full,
   output logic [G_NUM_REQ-1:0]          o_ack,
   output logic                          o_wr,
   output logic [G_WIDTH-1:0]            o_data,
   output logic [$clog2(G_NUM_REQ)-1:0]  o_grant_id,
   output logic                          o_busy
);

   localparam int C_ARB_ID_W  = f_id_w(G_NUM_REQ);
   localparam int C_ARB_CNT_W = f_cnt_w(G_BURST);
   localparam logic [C_ARB_CNT_W-1:0] C_LAST_BEAT = C_ARB_CNT_W'(G_BURST - 1);
   localparam logic [C_ARB_ID_W-1:0]  C_LAST_RST  = C_ARB_ID_W'(G_NUM_REQ - 1);

   arb_state_t               state, state_next;
   logic [C_ARB_ID_W-1:0]    owner, owner_next;
   logic [C_ARB_ID_W-1:0]    last, last_next;
   logic [C_ARB_CNT_W-1:0]   beat_cnt, beat_cnt_next;

   logic                     pick_valid;
   logic [C_ARB_ID_W-1:0]    pick_winner;
   logic                     wr;
   logic                     rel_grant;
   logic [G_NUM_REQ-1:0]     ack;
   logic [G_WIDTH-1:0]       data;

   // One picker serves both the idle path and the release/regrant path;
   // in both cases the previous winner is the lowest-priority candidate.
   rr_picker #(
      .G_N    (G_NUM_REQ),
      .G_ID_W (C_ARB_ID_W)
   ) u_picker (
      .req    (i_req),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         owner    <= '0;
         last     <= C_LAST_RST;
         beat_cnt <= '0;
      end else begin
         state    <= state_next;
         owner    <= owner_next;
         last     <= last_next;
         beat_cnt <= beat_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      owner_next    = owner;
      last_next     = last;
      beat_cnt_next = beat_cnt;
      wr            = 1'b0;
      rel_grant     = 1'b0;
      ack           = '0;
      data          = '0;

      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_next    = ST_GRANT;
               owner_next    = pick_winner;
               last_next     = pick_winner;
               beat_cnt_next = '0;
            end
         end

         ST_GRANT: begin
            wr         = i_req[owner] & ~i_fifo_full;
            ack[owner] = wr;
            data       = i_data[owner*G_WIDTH +: G_WIDTH];

            if (wr) begin
               beat_cnt_next = beat_cnt + C_ARB_CNT_W'(1);
            end

            // A stall (full, request held) keeps the grant; only a dropped
            // request or the final accepted beat ends it.
            rel_grant = ~i_req[owner] | (wr & (beat_cnt == C_LAST_BEAT));

            if (rel_grant) begin
               if (pick_valid) begin
                  state_next    = ST_GRANT;
                  owner_next    = pick_winner;
                  last_next     = pick_winner;
                  beat_cnt_next = '0;
               end else begin
                  state_next    = ST_IDLE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign o_wr       = wr;
   assign o_ack      = ack;
   assign o_data     = data;
   assign o_grant_id = owner;
   assign o_busy     = (state == ST_GRANT);

   a_no_wr_when_full : assert property (@(posedge i_clk) disable iff (i_rst)
      !(o_wr && i_fifo_full));

   a_ack_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0(o_ack));

endmodule
